svm_axis_bram_loader: RTL and testbench
=======================================

SVM_AXIS_BRAM_LOADER -- requirements
Module: svm_axis_bram_loader

Interface
REQ-001 Parameters SHALL be:
- WIDTH, default 16, BRAM sample width.
- C_S_AXIS_TDATA_WIDTH, default 32, stream width; an integer multiple of WIDTH.
- LANES = C_S_AXIS_TDATA_WIDTH/WIDTH, derived; the number of samples per beat.
- ADDR_INC, default 4, byte increment between consecutive BRAM samples.
- LEN_WIDTH, default 16, width of frame_len.
REQ-002 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 start  in  1  begins a frame when sampled high in IDLE.
REQ-005 base_addr  in  32  BRAM byte address of the first sample, latched on start.
REQ-006 frame_len  in  LEN_WIDTH  samples in the frame, latched on start.
REQ-007 s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH  stream beat; lane 0 is the LSBs.
REQ-008 s_axis_tvalid  in  1; s_axis_tlast  in  1; s_axis_tready  out  1.
REQ-009 axi_address  out  32; axi_in_data  out  WIDTH; axi_en  out  1; axi_we  out  4  BRAM write port.
REQ-010 done_interrupt  out  1  one-cycle frame-complete pulse.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 err_tlast  out  1  sticky tlast-framing error flag.

Function
REQ-013 The FSM SHALL have four states: IDLE, RECV, UNPACK and DONE.
REQ-014 In IDLE, start=1 with frame_len!=0 SHALL latch base_addr and frame_len, clear the sample count cnt and err_tlast, and go to RECV.
REQ-015 In IDLE, start=1 with frame_len=0 SHALL be ignored.
REQ-016 start in any state other than IDLE SHALL be ignored.
REQ-017 s_axis_tready SHALL be 1 only in RECV.
REQ-018 In RECV, a beat SHALL be accepted when tvalid&tready; the FSM then captures tdata and tlast into a beat register, sets the lane index to 0 and goes to UNPACK.
REQ-019 In RECV with tvalid=0, the FSM SHALL stay in RECV with axi_en=0.
REQ-020 Each UNPACK cycle SHALL drive:
- axi_en=1, axi_we=4'b1111;
- axi_in_data = lane[index];
- axi_address = base + cnt*ADDR_INC, modulo 2^32 (wrap, no error).
REQ-021 Each UNPACK cycle SHALL then increment cnt and the lane index.
REQ-022 The first write SHALL occur in the cycle after beat acceptance, and a beat SHALL occupy at most LANES+1 cycles.
REQ-023 UNPACK SHALL exit when cnt+1 equals frame_len, or when the lane index equals LANES-1, whichever is first.
REQ-024 Lanes beyond frame_len SHALL be discarded, with no write.
REQ-025 On UNPACK exit, the FSM SHALL go to DONE if the frame is complete or the captured tlast=1; otherwise it SHALL return to RECV.
REQ-026 The final beat is the beat containing sample frame_len-1.
REQ-027 err_tlast SHALL be set when tlast=1 on a non-final beat (early termination, fewer than frame_len writes).
REQ-028 err_tlast SHALL also be set when the final beat has tlast=0.
REQ-029 DONE SHALL last one cycle with done_interrupt=1 and then return to IDLE.
REQ-030 err_tlast SHALL hold until the next accepted start or reset.
REQ-031 Outside UNPACK, axi_en and axi_we SHALL be 0, and axi_address and axi_in_data SHALL hold their last values.
REQ-032 frame_len up to 2^LEN_WIDTH-1 SHALL be supported, with the counter wide enough that it never wraps.

Reset
REQ-033 While rst=0, the block SHALL be in IDLE with all outputs 0: tready, en, we, address, data, done_interrupt, busy and err_tlast.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately; a frame after reset release SHALL behave as a fresh start.

Verification (WIDTH=16, TDATA=32, LANES=2, ADDR_INC=4)
REQ-035 start, base=0x100, len=4; beats 0xBBBBAAAA then 0xDDDDCCCC with tlast -> writes AAAA@0x100, BBBB@0x104, CCCC@0x108, DDDD@0x10C; one done pulse; err_tlast=0.
REQ-036 len=3, beats as REQ-035 -> three writes ending CCCC@0x108; DDDD is not written; done pulse; err_tlast=0.
REQ-037 len=4, tlast on the first beat -> two writes, then done; err_tlast=1 until the next start.
REQ-038 len=4, final beat without tlast -> four writes, done pulse, err_tlast=1.
REQ-039 tvalid gaps of 3 cycles between beats, plus start pulsed while busy -> no writes and no tready during gaps; the start is ignored; the result is identical to REQ-035.
REQ-040 rst=0 after the second write of a len=4 frame -> all outputs 0 the same cycle; after release, a new frame with base=0x200 writes starting at 0x200.

Source files
------------

// File: rtl/svm_axis_bram_loader.sv
// AXI-Stream to BRAM loader.
// Accepts beats of LANES packed samples and writes them one sample per cycle
// to a BRAM port at base + n*ADDR_INC. It raises a one-cycle done pulse at
// frame end and keeps a sticky flag when tlast does not line up with frame_len.
// Every output is a register loaded from the next-state decision, so it lines
// up with the state the FSM is entering.
module svm_axis_bram_loader #(
    parameter int WIDTH                = 16,
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int ADDR_INC             = 4,
    parameter int LEN_WIDTH            = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [31:0]                     base_addr,
    input  logic [LEN_WIDTH-1:0]            frame_len,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [31:0]                     axi_address,
    output logic [WIDTH-1:0]                axi_in_data,
    output logic                            axi_en,
    output logic [3:0]                      axi_we,
    output logic                            done_interrupt,
    output logic                            busy,
    output logic                            err_tlast
);

    localparam int LANES = C_S_AXIS_TDATA_WIDTH / WIDTH;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        UNPACK = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                            state_r;
    state_t                            state_nxt_s;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   beat_r;
    logic                              tlast_r;
    logic [IDX_W-1:0]                  idx_r;
    logic [LEN_WIDTH-1:0]              cnt_r;
    logic [LEN_WIDTH-1:0]              len_r;
    logic [31:0]                       addr_acc_r;
    logic                              err_r;
    logic                              en_r;
    logic                              tready_r;
    logic                              busy_r;
    logic                              done_r;
    logic [31:0]                       address_r;
    logic [WIDTH-1:0]                  data_r;

    logic                              accept_s;
    logic                              start_ok_s;
    logic                              last_sample_s;
    logic                              last_lane_s;
    logic                              unpack_exit_s;
    logic [IDX_W-1:0]                  idx_nxt_s;
    logic [31:0]                       addr_nxt_s;

    // Pick one sample lane out of a captured beat; lane 0 sits in the LSBs.
    function automatic logic [WIDTH-1:0] lane_sel(
        input logic [C_S_AXIS_TDATA_WIDTH-1:0] beat,
        input logic [IDX_W-1:0]                idx
    );
        lane_sel = beat[int'(idx)*WIDTH +: WIDTH];
    endfunction

    // tready mirrors RECV, so tvalid alone qualifies a handshake there.
    assign accept_s      = (state_r == RECV) && s_axis_tvalid;
    assign start_ok_s    = (state_r == IDLE) && start && (frame_len != '0);
    // cnt_r never exceeds len_r-1 inside UNPACK, so cnt_r+1 cannot overflow.
    assign last_sample_s = ((cnt_r + LEN_WIDTH'(1)) == len_r);
    assign last_lane_s   = (idx_r == IDX_W'(LANES - 1));
    assign unpack_exit_s = last_sample_s || last_lane_s;
    assign idx_nxt_s     = idx_r + IDX_W'(1);
    assign addr_nxt_s    = addr_acc_r + 32'(ADDR_INC);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = RECV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RECV: begin
                if (accept_s) begin
                    state_nxt_s = UNPACK;
                end else begin
                    state_nxt_s = RECV;
                end
            end
            UNPACK: begin
                if (!unpack_exit_s) begin
                    state_nxt_s = UNPACK;
                end else if (last_sample_s || tlast_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RECV;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Frame context, beat capture, sample counters and write-port data/address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_r     <= '0;
            tlast_r    <= 1'b0;
            idx_r      <= '0;
            cnt_r      <= '0;
            len_r      <= '0;
            addr_acc_r <= 32'h0000_0000;
            err_r      <= 1'b0;
            address_r  <= 32'h0000_0000;
            data_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        addr_acc_r <= base_addr;
                        len_r      <= frame_len;
                        cnt_r      <= '0;
                        err_r      <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        beat_r    <= s_axis_tdata;
                        tlast_r   <= s_axis_tlast;
                        idx_r     <= '0;
                        data_r    <= s_axis_tdata[WIDTH-1:0];
                        address_r <= addr_acc_r;
                    end
                end
                UNPACK: begin
                    cnt_r      <= cnt_r + LEN_WIDTH'(1);
                    idx_r      <= idx_nxt_s;
                    addr_acc_r <= addr_nxt_s;
                    if (unpack_exit_s) begin
                        // Final beat must carry tlast; any earlier beat must not.
                        if (last_sample_s) begin
                            err_r <= err_r | ~tlast_r;
                        end else begin
                            err_r <= err_r | tlast_r;
                        end
                    end else begin
                        data_r    <= lane_sel(beat_r, idx_nxt_s);
                        address_r <= addr_nxt_s;
                    end
                end
                DONE: begin
                    err_r <= err_r;
                end
                default: begin
                    err_r <= err_r;
                end
            endcase
        end
    end

    // Status and strobe outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_r     <= 1'b0;
            tready_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            en_r     <= (state_nxt_s == UNPACK);
            tready_r <= (state_nxt_s == RECV);
            busy_r   <= (state_nxt_s != IDLE);
            done_r   <= (state_nxt_s == DONE);
        end
    end

    assign s_axis_tready  = tready_r;
    assign axi_en         = en_r;
    assign axi_we         = {4{en_r}};
    assign axi_address    = address_r;
    assign axi_in_data    = data_r;
    assign done_interrupt = done_r;
    assign busy           = busy_r;
    assign err_tlast      = err_r;

endmodule

// File: tb/tb_svm_axis_bram_loader.sv
// Randomised self-checking bench for svm_axis_bram_loader (16-bit samples, 2 lanes).
module tb_svm_axis_bram_loader;

    localparam int WIDTH     = 16;
    localparam int TDW       = 32;
    localparam int LANES     = 2;
    localparam int ADDR_INC  = 4;
    localparam int LEN_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic [31:0]          base_addr = 32'h0;
    logic [LEN_WIDTH-1:0] frame_len = '0;
    logic [TDW-1:0]       s_axis_tdata = '0;
    logic                 s_axis_tvalid = 1'b0;
    logic                 s_axis_tlast = 1'b0;
    logic                 s_axis_tready;
    logic [31:0]          axi_address;
    logic [WIDTH-1:0]     axi_in_data;
    logic                 axi_en;
    logic [3:0]           axi_we;
    logic                 done_interrupt;
    logic                 busy;
    logic                 err_tlast;

    svm_axis_bram_loader #(
        .WIDTH(WIDTH), .C_S_AXIS_TDATA_WIDTH(TDW), .ADDR_INC(ADDR_INC), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .frame_len(frame_len),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .axi_address(axi_address), .axi_in_data(axi_in_data),
        .axi_en(axi_en), .axi_we(axi_we), .done_interrupt(done_interrupt), .busy(busy),
        .err_tlast(err_tlast)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         log_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          done_cnt = 0;
    logic        exp_err;
    int          beats_used;
    logic [31:0] last_addr = 32'h0;
    logic [15:0] last_data = 16'h0;
    logic [31:0] beat_data [16];
    logic        beat_last [16];
    int          n_beats;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Every-cycle comparison of the write port and status against the model queue.
    always @(negedge clk) begin
        if (!rst) begin
            last_addr = 32'h0;
            last_data = 16'h0;
        end else begin
            if (axi_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             axi_address, axi_in_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(axi_address), 64'(e.addr));
                    chk("wr_data", 64'(axi_in_data), 64'(e.data));
                end
                chk("wr_we", 64'(axi_we), 64'(4'hF));
                chk("tready_during_write", 64'(s_axis_tready), 64'(1'b0));
                log_q.push_back('{addr: axi_address, data: axi_in_data});
                last_addr = axi_address;
                last_data = axi_in_data;
            end else begin
                chk("we_idle", 64'(axi_we), 64'(4'h0));
                chk("addr_hold", 64'(axi_address), 64'(last_addr));
                chk("data_hold", 64'(axi_in_data), 64'(last_data));
            end
            if (done_interrupt) done_cnt++;
            if (!busy) chk("tready_not_busy", 64'(s_axis_tready), 64'(1'b0));
        end
    end

    // Frame model: samples in lane order until frame_len samples or a tlast beat.
    task automatic build_model(input logic [31:0] base, input int len);
        int n;
        n = 0;
        exp_err = 1'b0;
        beats_used = 0;
        for (int b = 0; b < n_beats; b++) begin
            beats_used = b + 1;
            for (int l = 0; l < LANES; l++) begin
                if (n < len) begin
                    exp_q.push_back('{addr: base + 32'(n * ADDR_INC),
                                      data: beat_data[b][l*WIDTH +: WIDTH]});
                    n++;
                end
            end
            if (n == len) begin
                exp_err = !beat_last[b];
                break;
            end else if (beat_last[b]) begin
                exp_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tready"}, 64'(s_axis_tready), 64'(0));
        chk({tag, "_en"},     64'(axi_en), 64'(0));
        chk({tag, "_we"},     64'(axi_we), 64'(0));
        chk({tag, "_addr"},   64'(axi_address), 64'(0));
        chk({tag, "_data"},   64'(axi_in_data), 64'(0));
        chk({tag, "_done"},   64'(done_interrupt), 64'(0));
        chk({tag, "_busy"},   64'(busy), 64'(0));
        chk({tag, "_err"},    64'(err_tlast), 64'(0));
    endtask

    task automatic start_frame(input logic [31:0] base, input int len);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; frame_len = LEN_WIDTH'(len);
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; frame_len = LEN_WIDTH'($urandom);
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("err_clear_on_start", 64'(err_tlast), 64'(0));
    endtask

    task automatic send_beat(input int b);
        bit ok;
        ok = 1'b0;
        s_axis_tdata = beat_data[b]; s_axis_tlast = beat_last[b]; s_axis_tvalid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (s_axis_tready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL tready_timeout: got tready 0 for 50 cycles, expected 1");
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0; s_axis_tdata = $urandom; s_axis_tlast = 1'($urandom);
    endtask

    task automatic run_frame(input logic [31:0] base, input int len, input int gap, input bit poke);
        bit ok;
        build_model(base, len);
        done_cnt = 0;
        start_frame(base, len);
        for (int b = 0; b < beats_used; b++) begin
            send_beat(b);
            for (int g = 0; g < gap; g++) begin
                if (poke && g == 1) begin
                    start = 1'b1; base_addr = 32'hDEAD_0000; frame_len = LEN_WIDTH'(7);
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
            end
            start = 1'b0;
        end
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL busy_timeout: got busy 1 for 50 cycles, expected 0");
        end
        chk("writes_left", 64'(exp_q.size()), 64'(0));
        chk("done_pulses", 64'(done_cnt), 64'(1));
        chk("err_tlast", 64'(err_tlast), 64'(exp_err));
    endtask

    task automatic set_req035_beats();
        n_beats = 2;
        beat_data[0] = 32'hBBBB_AAAA; beat_last[0] = 1'b0;
        beat_data[1] = 32'hDDDD_CCCC; beat_last[1] = 1'b1;
    endtask

    task automatic pin_req035(input string tag, input int i0);
        logic [31:0] pa [4];
        logic [15:0] pd [4];
        pa = '{32'h100, 32'h104, 32'h108, 32'h10C};
        pd = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        chk({tag, "_count"}, 64'(log_q.size() - i0), 64'(4));
        for (int k = 0; k < 4; k++) begin
            if (i0 + k < log_q.size()) begin
                chk({tag, "_addr"}, 64'(log_q[i0+k].addr), 64'(pa[k]));
                chk({tag, "_data"}, 64'(log_q[i0+k].data), 64'(pd[k]));
            end
        end
    endtask

    initial begin
        int i0;
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b1;

        // Basic frame, four samples over two beats.
        set_req035_beats();
        i0 = log_q.size();
        run_frame(32'h100, 4, 0, 1'b0);
        pin_req035("req035", i0);
        chk("req035_err", 64'(err_tlast), 64'(0));

        // Odd length: upper lane of the last beat is dropped.
        set_req035_beats();
        i0 = log_q.size();
        run_frame(32'h100, 3, 0, 1'b0);
        chk("req036_count", 64'(log_q.size() - i0), 64'(3));
        chk("req036_last", 64'(log_q[log_q.size()-1]), 64'({32'h108, 16'hCCCC}));

        // Early tlast on the first beat.
        set_req035_beats();
        beat_last[0] = 1'b1;
        i0 = log_q.size();
        run_frame(32'h100, 4, 0, 1'b0);
        chk("req037_count", 64'(log_q.size() - i0), 64'(2));
        chk("req037_err", 64'(err_tlast), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("req037_err_sticky", 64'(err_tlast), 64'(1));

        // Final beat missing tlast.
        set_req035_beats();
        beat_last[1] = 1'b0;
        i0 = log_q.size();
        run_frame(32'h100, 4, 0, 1'b0);
        chk("req038_count", 64'(log_q.size() - i0), 64'(4));
        chk("req038_err", 64'(err_tlast), 64'(1));

        // Gaps between beats with a start pulse while busy.
        set_req035_beats();
        i0 = log_q.size();
        run_frame(32'h100, 4, 3, 1'b1);
        pin_req035("req039", i0);

        // Zero-length start is ignored.
        @(posedge clk); #1;
        start = 1'b1; frame_len = '0; base_addr = 32'h300;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("len0_busy", 64'(busy), 64'(0));

        // Reset after the second write of a len=4 frame.
        set_req035_beats();
        build_model(32'h180, 4);
        start_frame(32'h180, 4);
        i0 = log_q.size();
        send_beat(0);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (log_q.size() - i0 >= 2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("req040_two_writes", 64'(ok), 64'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_outputs_zero("req040_mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_req035_beats();
        i0 = log_q.size();
        run_frame(32'h200, 4, 0, 1'b0);
        chk("req040_first_addr", 64'(log_q[i0].addr), 64'(32'h200));

        // Randomised frames, some with wrapping base addresses and bad tlast.
        for (int it = 0; it < 40; it++) begin
            int len;
            int mode;
            logic [31:0] base;
            len = $urandom_range(1, 9);
            n_beats = (len + LANES - 1) / LANES;
            base = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                               : 32'($urandom);
            mode = $urandom_range(0, 2);
            for (int b = 0; b < n_beats; b++) begin
                beat_data[b] = $urandom;
                beat_last[b] = 1'b0;
            end
            if (mode == 0) beat_last[n_beats-1] = 1'b1;
            else if (mode == 2 && n_beats > 1) beat_last[$urandom_range(0, n_beats - 2)] = 1'b1;
            run_frame(base, len, $urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
